// File: rtl/div_unit.sv
// div_unit -- multi-cycle 32-bit divider for the execute stage (DIV / DIVU).
// One restoring-division step per clock; the result is returned as
// {remainder, quotient} and held until the requester drops start_i.
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous reset, active low
//   signed_div_i  1 = two's-complement divide, 0 = unsigned
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request, held until the cycle after ready_o is seen
//   annul_i       abort any in-flight operation
//   result_o      {remainder[31:0], quotient[31:0]}, registered
//   ready_o       result valid, registered
//
// State table
//   ST_FREE   | idle, outputs zero, accepts a new request
//   ST_BYZERO | divisor was zero, report a zero result next edge
//   ST_ON     | iterating, one quotient bit per clock
//   ST_END    | result valid, held while start_i stays high
module div_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o
);

   typedef enum logic [1:0] {ST_FREE, ST_BYZERO, ST_ON, ST_END} state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   // Working register W without its top bit: W[64] never feeds a later step,
   // so it is only taken from the combinational step on the final iteration.
   logic [63:0] w_q, w_d;
   logic [31:0] dvs_q, dvs_d;
   logic        sign1_q, sign1_d;
   logic        sign2_q, sign2_d;
   logic        sgn_q, sgn_d;
   logic [63:0] result_q, result_d;
   logic        ready_q, ready_d;

   logic [32:0] diff;
   logic [64:0] w_step;
   logic [31:0] mag1, mag2;
   logic [31:0] quo_fix, rem_fix;
   logic        last_step;
   logic        accept;

   assign diff      = {1'b0, w_q[63:32]} - {1'b0, dvs_q};
   assign last_step = (cnt_q == 6'd31);
   assign accept    = start_i && !annul_i;

   always_comb begin
      if (diff[32]) begin
         w_step = {w_q[63:0], 1'b0};
      end else begin
         w_step = {diff[31:0], w_q[31:0], 1'b1};
      end
   end

   // Magnitudes; 0x80000000 stays 0x80000000 and is treated as unsigned.
   assign mag1 = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
   assign mag2 = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

   assign quo_fix = (sgn_q && (sign1_q ^ sign2_q)) ? (~w_step[31:0] + 32'd1) : w_step[31:0];
   assign rem_fix = (sgn_q && sign1_q) ? (~w_step[64:33] + 32'd1) : w_step[64:33];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_FREE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FREE: begin
            if (accept) begin
               state_d = (opdata2_i == 32'd0) ? ST_BYZERO : ST_ON;
            end
         end
         ST_BYZERO: state_d = annul_i ? ST_FREE : ST_END;
         ST_ON: begin
            if (annul_i) begin
               state_d = ST_FREE;
            end else if (last_step) begin
               state_d = ST_END;
            end
         end
         ST_END: begin
            if (!start_i) begin
               state_d = ST_FREE;
            end
         end
         default: state_d = ST_FREE;
      endcase
   end

   always_comb begin
      cnt_d    = cnt_q;
      w_d      = w_q;
      dvs_d    = dvs_q;
      sign1_d  = sign1_q;
      sign2_d  = sign2_q;
      sgn_d    = sgn_q;
      result_d = result_q;
      ready_d  = ready_q;
      case (state_q)
         ST_FREE: begin
            cnt_d    = 6'd0;
            result_d = 64'd0;
            ready_d  = 1'b0;
            if (accept && (opdata2_i != 32'd0)) begin
               w_d     = {31'd0, mag1, 1'b0};
               dvs_d   = mag2;
               sign1_d = opdata1_i[31];
               sign2_d = opdata2_i[31];
               sgn_d   = signed_div_i;
            end
         end
         ST_BYZERO: begin
            result_d = 64'd0;
            ready_d  = !annul_i;
         end
         ST_ON: begin
            if (annul_i) begin
               cnt_d    = 6'd0;
               result_d = 64'd0;
               ready_d  = 1'b0;
            end else begin
               w_d   = w_step[63:0];
               cnt_d = cnt_q + 6'd1;
               if (last_step) begin
                  result_d = {rem_fix, quo_fix};
                  ready_d  = 1'b1;
               end
            end
         end
         ST_END: begin
            if (!start_i) begin
               result_d = 64'd0;
               ready_d  = 1'b0;
            end
         end
         default: begin
            result_d = 64'd0;
            ready_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q    <= 6'd0;
         w_q      <= 64'd0;
         dvs_q    <= 32'd0;
         sign1_q  <= 1'b0;
         sign2_q  <= 1'b0;
         sgn_q    <= 1'b0;
         result_q <= 64'd0;
         ready_q  <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         w_q      <= w_d;
         dvs_q    <= dvs_d;
         sign1_q  <= sign1_d;
         sign2_q  <= sign2_d;
         sgn_q    <= sgn_d;
         result_q <= result_d;
         ready_q  <= ready_d;
      end
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit divider for the MIPS execute stage; it serves DIV and DIVU. The EX stage starts an operation and stalls the pipeline until `ready_o`. The block then returns the 64-bit result, which the EX stage writes to HI/LO through the existing `whilo_o`/`hi_o`/`lo_o` path: HI takes the remainder and LO takes the quotient. It uses a four-state FSM and one restoring-division iteration per clock.

## Interface
- No parameters; width fixed at 32-bit operands, 64-bit result.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset asserted, applied immediately, released synchronously to `clk` by the top level).
- `signed_div_i`  in  1  1 = DIV (two's complement), 0 = DIVU.
- `opdata1_i`  in  32  dividend.
- `opdata2_i`  in  32  divisor.
- `start_i`  in  1  request; held high by EX until the cycle after `ready_o` is seen.
- `annul_i`  in  1  cancel (branch-delay flush/exception); aborts any in-flight operation.
- `result_o`  out  64  {remainder[31:0], quotient[31:0]}; registered.
- `ready_o`  out  1  result valid; registered.

## Operation
- States: FREE, BYZERO, ON, END. Reset: state FREE, `ready_o`=0, `result_o`=0, iteration counter=0, internal dividend/divisor regs=0.
- FREE: if `start_i`=1 and `annul_i`=0:
  - If `opdata2_i`=0, go to BYZERO.
  - Otherwise, latch the operands and go to ON with counter=0.
  - Otherwise, stay in FREE; outputs are 0.
- Operand conditioning at latch: if `signed_div_i`=1 and an operand's bit31=1, latch its two's-complement magnitude (~x+1); else latch it unchanged. Also latch sign1=`opdata1_i`[31], sign2=`opdata2_i`[31] and `signed_div_i`.
  - 0x80000000 magnitude is 0x80000000, interpreted unsigned.
- Restoring iteration, used in ON:
  - Working register W is 65 bits, initialised to {32'b0, |dividend|, 1'b0}.
  - Each cycle, compute T = {1'b0, W[63:32]} − {1'b0, |divisor|}.
  - If T[32]=1, W = W<<1.
  - Otherwise, W = {T[31:0], W[31:0], 1'b1}.
  - Increment the counter.
- ON to END when the counter reaches 32, that is, on the edge performing iteration 32.
  - At that same edge, the quotient magnitude is the low word and the remainder magnitude is the high word.
  - If signed: quotient = −q when sign1≠sign2, remainder = −r when sign1=1, both in 32-bit wrap arithmetic.
  - Load `result_o` = {rem, quo} and set `ready_o`=1.
- BYZERO: the next edge goes to END with `result_o`=0 and `ready_o`=1.
- END: hold `result_o` and `ready_o`=1 while `start_i`=1.
  - When `start_i`=0, the next edge goes to FREE and clears `ready_o` and `result_o` to 0.
- `annul_i`=1 in ON or BYZERO: the next edge goes to FREE, clears the counter and outputs, and no `ready_o` pulse occurs.
  - `annul_i` in END is ignored; EX drops `start_i`.
- Operand inputs are ignored outside FREE; a change mid-operation has no effect.
- `start_i` deasserted in ON without `annul_i`: the operation continues and the block enters END, where it exits on the next edge because `start_i`=0.

## Timing
- Start accepted at edge E0 (state FREE, `start_i`=1).
- Normal path: iterations occur on edges E1..E32. `ready_o`=1 and `result_o` are valid after E32, so the latency is 32 cycles after acceptance.
- Divide-by-zero: BYZERO after E0, END with `ready_o`=1 after E1.
- Return to FREE takes exactly one edge after `start_i` is sampled low in END. A new start can be accepted at the following edge, so the minimum issue interval is 35 edges.
- Asynchronous reset at any point forces FREE and all outputs to 0 without waiting for a clock. After release, the first edge behaves as FREE.
- No combinational path from any input to any output.

## Test plan
- DIVU 100/7, start held: `ready_o` rises after exactly 32 edges from acceptance with `result_o` = 0x00000002_0000000E. Dropping `start_i` clears both one edge later.
- DIV −7/2 (0xFFFFFFF9, 0x00000002): `result_o` = 0xFFFFFFFF_FFFFFFFD. Also check 7/−2, which gives 0x00000001_FFFFFFFD.
- DIV 0x80000000/0xFFFFFFFF gives 0x00000000_80000000. DIVU 0xFFFFFFFF/1 gives 0x00000000_FFFFFFFF.
- Divisor 0, either signedness: `ready_o`=1 after 2 edges with `result_o`=0. Operand changes while in END do not alter `result_o`.
- Annul after iteration 10: state returns to FREE and `ready_o` never asserts. An immediate new DIVU 9/3 then completes with 0x00000000_00000003.
- Assert `rst`=0 asynchronously mid-ON: `ready_o` and `result_o` go to 0 before the next edge. After release, a fresh 100/7 completes with normal 32-cycle latency.
